// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } div_state_e;

    localparam int unsigned DIV_ITERS   = 32;
    localparam int unsigned DIV_LATENCY = 34;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R, Q} left, trial-subtract D from R,
// keep the difference and set Q[0] only when the subtract does not borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0] rq_in,
    input  logic [WIDTH-1:0] d,
    output logic [2*WIDTH:0] rq_out
);

    logic [2*WIDTH:0] sh;
    logic [WIDTH+1:0] trial;

    always_comb begin
        // R stays below D, so the bit shifted out of R's MSB is always zero
        sh     = rq_in << 1;
        trial  = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, d};
        rq_out = sh;
        if (!trial[WIDTH+1]) begin
            rq_out[2*WIDTH:WIDTH] = trial[WIDTH:0];
            rq_out[0]             = 1'b1;
        end
    end

endmodule

// File: rtl/div_32seq.sv
// Iterative restoring divider with start/done handshake, fixed 34-cycle latency.
// Define DIV_SIGNED_EN for two's-complement signed division.
module div_32seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(DIV_ITERS) + 1;

    div_state_e       state_q, state_nx;
    logic [WIDTH-1:0] a_q, d_q;
    logic [2*WIDTH:0] rq_q, rq_step;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_mag, d_mag;
    logic [WIDTH-1:0] q_raw, r_raw, q_fix, r_fix;

    assign q_raw = rq_q[WIDTH-1:0];
    assign r_raw = WIDTH'(rq_q[2*WIDTH:WIDTH]);

`ifdef DIV_SIGNED_EN
    logic q_neg_q, r_neg_q;

    assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
    assign d_mag = d_q[WIDTH-1] ? -d_q : d_q;
    assign q_fix = q_neg_q ? -q_raw : q_raw;
    assign r_fix = r_neg_q ? -r_raw : r_raw;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (state_q == PREP) begin
            q_neg_q <= a_q[WIDTH-1] ^ d_q[WIDTH-1];
            r_neg_q <= a_q[WIDTH-1];
        end
    end
`else
    assign a_mag = a_q;
    assign d_mag = d_q;
    assign q_fix = q_raw;
    assign r_fix = r_raw;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rq_in (rq_q),
        .d     (d_q),
        .rq_out(rq_step)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (start) state_nx = PREP;
            PREP:    state_nx = (d_q == '0) ? DONE : ITER;
            ITER:    if (cnt_q == CW'(1)) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_q       <= '0;
            d_q       <= '0;
            rq_q      <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q <= dividend;
                        d_q <= divisor;
                    end
                end
                PREP: begin
                    // a_q keeps the raw dividend; it is the divide-by-zero remainder
                    rq_q  <= {{(WIDTH+1){1'b0}}, a_mag};
                    d_q   <= d_mag;
                    cnt_q <= CW'(DIV_ITERS);
                    if (d_q == '0) begin
                        quotient  <= WIDTH'(DIV_ZERO_QUOT);
                        remainder <= a_q;
                        div_zero  <= 1'b1;
                    end
                end
                ITER: begin
                    rq_q  <= rq_step;
                    cnt_q <= cnt_q - CW'(1);
                end
                FIXUP: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    div_zero  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_32seq.sv
// Self-checking bench for div_32seq: directed table, handshake corner cases,
// and randomized operands against an arithmetic reference model.
module tb_div_32seq;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_zero;
    logic [31:0] quotient, remainder;

    int n_cmp = 0;
    int n_fail = 0;

    div_32seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        longint sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge
    // that takes the DUT back to IDLE.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit repulse,
                           output logic [31:0] q, output logic [31:0] r, output logic z,
                           output int lat, output bit busy_ok, output bit pulse_ok);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_ok = busy && !done;
        lat     = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (repulse && lat == 4) begin
                start    = 1'b1;
                dividend = 32'd999;
                divisor  = 32'd3;
            end
            if (repulse && lat == 5) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) break;
        end
        q = quotient;
        r = remainder;
        z = div_zero;
        @(posedge clk); #1;
        pulse_ok = !done && !busy;
    endtask

    initial begin
        logic [31:0] q, r, eq, er;
        logic        z, ez;
        int          lat;
        bit          bok, pok, seen;

        vecs.push_back('{32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
        vecs.push_back('{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1});
        vecs.push_back('{32'd0,          32'd5,          32'd0,          32'd0,          1'b0});
        vecs.push_back('{32'd7,          32'd7,          32'd1,          32'd0,          1'b0});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFFF,  32'h10,         32'd0,          32'hFFFF_FFFF,  1'b0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0});
        vecs.push_back('{32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  32'd0,          1'b0});
        vecs.push_back('{32'hFFFF_FF00,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF00,  1'b1});
`else
        vecs.push_back('{32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0});
        vecs.push_back('{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0});
`endif

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk) clr_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_div(vecs[i].a, vecs[i].b, 1'b0, q, r, z, lat, bok, pok);
            chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            chk($sformatf("vec%0d_div_zero", i), 32'(z), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].z ? 32'd1 : 32'(DIV_LATENCY));
            chk($sformatf("vec%0d_busy_window", i), 32'(bok), 32'd1);
            chk($sformatf("vec%0d_done_single", i), 32'(pok), 32'd1);
            chk($sformatf("vec%0d_hold_quotient", i), quotient, vecs[i].q);
        end

        // start re-pulsed mid-operation must be ignored
        run_div(32'd100, 32'd7, 1'b1, q, r, z, lat, bok, pok);
        chk("repulse_quotient", q, 32'd14);
        chk("repulse_remainder", r, 32'd2);
        chk("repulse_latency", 32'(lat), 32'(DIV_LATENCY));
        chk("repulse_done_single", 32'(pok), 32'd1);
        @(posedge clk); #1;
        chk("repulse_no_second_run", 32'(busy), 32'd0);

        // asynchronous abort in the middle of an operation
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3 clr_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk) clr_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_div(32'd1000, 32'd33, 1'b0, q, r, z, lat, bok, pok);
        chk("post_abort_quotient", q, 32'd30);
        chk("post_abort_remainder", r, 32'd10);
        chk("post_abort_latency", 32'(lat), 32'(DIV_LATENCY));

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            int unsigned mode;
            a    = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0)      b = 32'd0;
            else if (mode <= 3) b = $urandom_range(1, 1000);
            else if (mode == 4) b = 32'hFFFF_FFFF - $urandom_range(0, 5);
            else                b = $urandom;
            model(a, b, eq, er, ez);
            run_div(a, b, 1'b0, q, r, z, lat, bok, pok);
            chk($sformatf("rnd%0d_quotient(%h/%h)", i, a, b), q, eq);
            chk($sformatf("rnd%0d_remainder(%h/%h)", i, a, b), r, er);
            chk($sformatf("rnd%0d_div_zero", i), 32'(z), 32'(ez));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), ez ? 32'd1 : 32'(DIV_LATENCY));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
